// File: rtl/core_inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// master = fetch + decode side, slave = the queue itself.
interface core_inst_queue_if #(
    parameter int ATTACHED_INFO_WIDTH    = 32,
    parameter int F2_ATTACHED_INFO_WIDTH = 32
);
    logic                                         flush_i;
    logic [1:0]                                   valid_i;
    logic [1:0][31:0]                             inst_i;
    logic [31:0]                                  pc_i;
    logic [ATTACHED_INFO_WIDTH-1:0]               attached_i;
    logic [F2_ATTACHED_INFO_WIDTH-1:0]            f2_attached_i;
    logic                                         ready_o;
    logic [1:0]                                   valid_o;
    logic [1:0][31:0]                             inst_o;
    logic [1:0][31:0]                             pc_o;
    logic [1:0][ATTACHED_INFO_WIDTH-1:0]          attached_o;
    logic [1:0][F2_ATTACHED_INFO_WIDTH-1:0]       f2_attached_o;
    logic [1:0]                                   ready_i;

    modport master (
        output flush_i, valid_i, inst_i, pc_i, attached_i, f2_attached_i, ready_i,
        input  ready_o, valid_o, inst_o, pc_o, attached_o, f2_attached_o
    );

    modport slave (
        input  flush_i, valid_i, inst_i, pc_i, attached_i, f2_attached_i, ready_i,
        output ready_o, valid_o, inst_o, pc_o, attached_o, f2_attached_o
    );
endinterface

// File: rtl/core_inst_queue.sv
// Instruction queue between fetch F2 and decode: compacts up to two words per
// packet into a circular buffer and presents the two oldest entries to decode.
module core_inst_queue #(
    parameter int DEPTH                  = 8,
    parameter int ATTACHED_INFO_WIDTH    = 32,
    parameter int F2_ATTACHED_INFO_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    core_inst_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_HI  = (PTR_W+1)'(DEPTH-2);

    typedef struct packed {
        logic [31:0]                        inst;
        logic [29:0]                        pc_word;
        logic [ATTACHED_INFO_WIDTH-1:0]     attached;
        logic [F2_ATTACHED_INFO_WIDTH-1:0]  f2_attached;
    } entry_t;

    // Head entries must be visible the cycle after they are written, so the
    // array is read asynchronously.
    entry_t mem [DEPTH];

    logic [PTR_W-1:0] rptr_reg;
    logic [PTR_W-1:0] wptr_reg;
    logic [PTR_W:0]   cnt_reg;
    logic [PTR_W-1:0] wptr_inc;

    logic       push_en;
    logic       push_two;
    logic       pop0;
    logic       pop1;
    logic [1:0] push_cnt;
    logic [1:0] pop_cnt;
    entry_t     slot_wdata [2];
    entry_t     first_wdata;
    logic       unused_pc_bits;

    assign unused_pc_bits = ^q.pc_i[2:0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wslot
            assign slot_wdata[gi] = '{
                inst:        q.inst_i[gi],
                pc_word:     {q.pc_i[31:3], (gi == 1)},
                attached:    q.attached_i,
                f2_attached: q.f2_attached_i
            };
        end
    endgenerate

    assign q.ready_o    = (cnt_reg <= CNT_HI);
    assign q.valid_o[0] = (cnt_reg >= CNT_ONE);
    assign q.valid_o[1] = (cnt_reg > CNT_ONE);

    assign push_en  = (|q.valid_i) && q.ready_o && !q.flush_i;
    assign push_two = q.valid_i[0] && q.valid_i[1];
    assign push_cnt = !push_en ? 2'd0 : (push_two ? 2'd2 : 2'd1);

    // A lone slot1 word is compacted down to the write pointer.
    assign first_wdata = q.valid_i[0] ? slot_wdata[0] : slot_wdata[1];
    assign wptr_inc    = wptr_reg + PTR_W'(1);

    assign pop0    = q.ready_i[0] && q.valid_o[0];
    assign pop1    = pop0 && q.ready_i[1] && q.valid_o[1];
    assign pop_cnt = pop1 ? 2'd2 : (pop0 ? 2'd1 : 2'd0);

    always_ff @(posedge clk) begin
        if (rst || q.flush_i) begin
            rptr_reg <= '0;
            wptr_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            rptr_reg <= rptr_reg + PTR_W'(pop_cnt);
            wptr_reg <= wptr_reg + PTR_W'(push_cnt);
            cnt_reg  <= cnt_reg + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop_cnt);
        end
    end

    // Data entries are never cleared; the count alone says what is live.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            mem[wptr_reg] <= first_wdata;
            if (push_two) begin
                mem[wptr_inc] <= slot_wdata[1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rslot
            logic [PTR_W-1:0] ridx;
            assign ridx                = rptr_reg + PTR_W'(gi);
            assign q.inst_o[gi]        = mem[ridx].inst;
            assign q.pc_o[gi]          = {mem[ridx].pc_word, 2'b00};
            assign q.attached_o[gi]    = mem[ridx].attached;
            assign q.f2_attached_o[gi] = mem[ridx].f2_attached;
        end
    endgenerate
endmodule

// File: tb/tb_core_inst_queue.sv
// Self-checking bench for core_inst_queue: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_core_inst_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_inst_queue_if #(.ATTACHED_INFO_WIDTH(32), .F2_ATTACHED_INFO_WIDTH(32)) qif ();

    core_inst_queue #(
        .DEPTH(DEPTH),
        .ATTACHED_INFO_WIDTH(32),
        .F2_ATTACHED_INFO_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q(qif)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] att;
        logic [31:0] f2;
    } ment_t;

    ment_t       model_q[$];
    logic [31:0] popped[$];
    bit          track = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: ordered list of live instructions.
    always @(posedge clk) begin
        int    n;
        bit    acc, p0, p1;
        ment_t e;
        if (track && !rst && !qif.flush_i && qif.valid_o[0] && qif.ready_i[0]) begin
            popped.push_back(qif.pc_o[0]);
            if (qif.valid_o[1] && qif.ready_i[1]) popped.push_back(qif.pc_o[1]);
        end
        if (rst || qif.flush_i) begin
            model_q.delete();
        end else begin
            n   = model_q.size();
            acc = (n <= DEPTH - 2);
            p0  = qif.ready_i[0] && (n >= 1);
            p1  = p0 && qif.ready_i[1] && (n >= 2);
            if (p0) void'(model_q.pop_front());
            if (p1) void'(model_q.pop_front());
            if (acc) begin
                for (int s = 0; s < 2; s++) begin
                    if (qif.valid_i[s]) begin
                        e.inst = qif.inst_i[s];
                        e.pc   = {qif.pc_i[31:3], s[0], 2'b00};
                        e.att  = qif.attached_i;
                        e.f2   = qif.f2_attached_i;
                        model_q.push_back(e);
                    end
                end
            end
        end
    end

    // Compare process: outputs depend only on state, so sample at negedge.
    always @(negedge clk) begin
        int n;
        if (!rst) begin
            n = model_q.size();
            chk("ready_o", {31'b0, qif.ready_o}, {31'b0, n <= DEPTH - 2});
            chk("valid_o", {30'b0, qif.valid_o}, (n >= 2) ? 32'd3 : (n == 1) ? 32'd1 : 32'd0);
            for (int s = 0; s < 2; s++) begin
                if (n > s) begin
                    chk("inst_o", qif.inst_o[s], model_q[s].inst);
                    chk("pc_o", qif.pc_o[s], model_q[s].pc);
                    chk("attached_o", qif.attached_o[s], model_q[s].att);
                    chk("f2_attached_o", qif.f2_attached_o[s], model_q[s].f2);
                end
            end
        end
    end

    task automatic cyc(input logic [1:0] v, input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [1:0] rdy, input logic fl);
        qif.valid_i       = v;
        qif.pc_i          = pc;
        qif.inst_i[0]     = i0;
        qif.inst_i[1]     = i1;
        qif.attached_i    = i0 ^ 32'h1111_1111;
        qif.f2_attached_i = ~pc;
        qif.ready_i       = rdy;
        qif.flush_i       = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] rdy);
        cyc(2'b00, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic flush();
        cyc(2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1);
    endtask

    initial begin
        logic [31:0] base, pcv;
        int          sent, budget;
        bit          acc;

        rst = 1'b1;
        qif.valid_i = 2'b00; qif.pc_i = '0; qif.inst_i = '0; qif.attached_i = '0;
        qif.f2_attached_i = '0; qif.ready_i = 2'b00; qif.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset valid_o", {30'b0, qif.valid_o}, 32'd0);
        chk("reset ready_o", {31'b0, qif.ready_o}, 32'd1);
        rst = 1'b0;

        // Basic two-wide push
        cyc(2'b11, 32'h1c00_0000, 32'hAAAA_0001, 32'hBBBB_0002, 2'b00, 1'b0);
        chk("t1 valid_o", {30'b0, qif.valid_o}, 32'd3);
        chk("t1 inst0", qif.inst_o[0], 32'hAAAA_0001);
        chk("t1 inst1", qif.inst_o[1], 32'hBBBB_0002);
        chk("t1 pc0", qif.pc_o[0], 32'h1c00_0000);
        chk("t1 pc1", qif.pc_o[1], 32'h1c00_0004);
        chk("t1 ready_o", {31'b0, qif.ready_o}, 32'd1);

        // Compaction
        flush();
        cyc(2'b10, 32'h1c00_0010, 32'hDEAD_0000, 32'hCCCC_0003, 2'b00, 1'b0);
        cyc(2'b01, 32'h1c00_0018, 32'hDDDD_0004, 32'hDEAD_0001, 2'b00, 1'b0);
        chk("cmp valid_o", {30'b0, qif.valid_o}, 32'd3);
        chk("cmp pc0", qif.pc_o[0], 32'h1c00_0014);
        chk("cmp pc1", qif.pc_o[1], 32'h1c00_0018);
        chk("cmp inst0", qif.inst_o[0], 32'hCCCC_0003);
        chk("cmp inst1", qif.inst_o[1], 32'hDDDD_0004);

        // Backpressure
        flush();
        for (int k = 0; k < 4; k++) begin
            chk("bp ready before push", {31'b0, qif.ready_o}, 32'd1);
            pcv = 32'h1c00_0100 + 32'(8 * k);
            cyc(2'b11, pcv, pcv ^ 32'h5000_0000, pcv ^ 32'h5000_0004, 2'b00, 1'b0);
        end
        chk("bp full ready_o", {31'b0, qif.ready_o}, 32'd0);
        pcv = 32'h1c00_0120;
        cyc(2'b11, pcv, 32'h6000_0000, 32'h6000_0004, 2'b00, 1'b0);
        cyc(2'b11, pcv, 32'h6000_0000, 32'h6000_0004, 2'b00, 1'b0);
        chk("bp held ready_o", {31'b0, qif.ready_o}, 32'd0);
        chk("bp held pc0", qif.pc_o[0], 32'h1c00_0100);
        cyc(2'b11, pcv, 32'h6000_0000, 32'h6000_0004, 2'b11, 1'b0);
        chk("bp cnt6 ready_o", {31'b0, qif.ready_o}, 32'd1);
        chk("bp cnt6 pc0", qif.pc_o[0], 32'h1c00_0108);
        cyc(2'b11, pcv, 32'h6000_0000, 32'h6000_0004, 2'b00, 1'b0);
        chk("bp refull ready_o", {31'b0, qif.ready_o}, 32'd0);
        repeat (4) idle(2'b11);
        chk("bp drained valid_o", {30'b0, qif.valid_o}, 32'd0);

        // Partial pop
        flush();
        cyc(2'b11, 32'h1c00_0200, 32'h7000_0000, 32'h7000_0004, 2'b00, 1'b0);
        cyc(2'b01, 32'h1c00_0208, 32'h7000_0008, 32'h0, 2'b00, 1'b0);
        idle(2'b01);
        chk("pp 01 pc0", qif.pc_o[0], 32'h1c00_0204);
        idle(2'b10);
        chk("pp 10 pc0", qif.pc_o[0], 32'h1c00_0204);
        cyc(2'b11, 32'h1c00_0210, 32'h7000_0010, 32'h7000_0014, 2'b11, 1'b0);
        chk("pp swap valid_o", {30'b0, qif.valid_o}, 32'd3);
        chk("pp swap pc0", qif.pc_o[0], 32'h1c00_0210);
        chk("pp swap pc1", qif.pc_o[1], 32'h1c00_0214);

        // Wrap-around stream
        flush();
        popped.delete();
        track  = 1;
        base   = 32'h1c00_1000;
        sent   = 0;
        budget = 0;
        while (sent < 40 && budget < 300) begin
            acc = qif.ready_o;
            pcv = base + 32'(8 * sent);
            cyc(2'b11, pcv, pcv ^ 32'h9000_0000, pcv ^ 32'h9000_0004,
                (sent < 20 || budget[0]) ? 2'b11 : 2'b01, 1'b0);
            if (acc) sent++;
            budget++;
        end
        chk("wrap packets sent", 32'(sent), 32'd40);
        budget = 0;
        while (qif.valid_o != 2'b00 && budget < 50) begin
            idle(2'b11);
            budget++;
        end
        chk("wrap drained", {30'b0, qif.valid_o}, 32'd0);
        track = 0;
        chk("wrap pop count", 32'(popped.size()), 32'd80);
        for (int i = 0; i < popped.size(); i++) begin
            chk("wrap pc order", popped[i], base + 32'(4 * i));
        end

        // Flush with concurrent push and pop
        cyc(2'b11, 32'h1c00_2000, 32'hA000_0000, 32'hA000_0004, 2'b00, 1'b0);
        cyc(2'b11, 32'h1c00_2008, 32'hA000_0008, 32'hA000_000c, 2'b00, 1'b0);
        cyc(2'b01, 32'h1c00_2010, 32'hA000_0010, 32'h0, 2'b00, 1'b0);
        chk("fl pre valid_o", {30'b0, qif.valid_o}, 32'd3);
        cyc(2'b11, 32'h1c00_2018, 32'hA000_0018, 32'hA000_001c, 2'b11, 1'b1);
        chk("fl valid_o", {30'b0, qif.valid_o}, 32'd0);
        chk("fl ready_o", {31'b0, qif.ready_o}, 32'd1);
        cyc(2'b01, 32'h1c00_2020, 32'hA000_0020, 32'h0, 2'b00, 1'b0);
        chk("fl after valid_o", {30'b0, qif.valid_o}, 32'd1);
        chk("fl after pc0", qif.pc_o[0], 32'h1c00_2020);
        chk("fl after inst0", qif.inst_o[0], 32'hA000_0020);
        idle(2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
